rwt_tag_extract: RTL and testbench

//  Removes in-band escape sequences from a 64-bit AXI-Stream and turns them into sideband tags.

---
 rtl/rwt_pkg.sv | 14 +
 rtl/rwt_axis_reg.sv | 47 ++++
 rtl/rwt_tag_extract.sv | 110 +++++++++++
 tb/tb_rwt_tag_extract.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rwt_pkg.sv
// Shared types and defaults for the tag-extract stream slice.
package rwt_pkg;

  localparam int DWIDTH_DEF  = 64;
  localparam int TTWIDTH_DEF = 7;

  // Escape decoder position within a sequence.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // plain data, or the start of a new sequence
    ESC  = 2'd1,  // an escape word has been consumed
    HDR  = 2'd2   // escape plus header consumed; next word is the tagged payload
  } state_t;

endpackage

// File: rtl/rwt_axis_reg.sv
// Output register slice: holds one beat (data, last, tag) under back-pressure
// and advertises room upstream whenever the slot is empty or draining.
module rwt_axis_reg
  import rwt_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int TTWIDTH = TTWIDTH_DEF
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               in_valid,
  input  logic [DWIDTH-1:0]  in_data,
  input  logic               in_last,
  input  logic               in_tag_valid,
  input  logic [TTWIDTH-1:0] in_tag_type,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DWIDTH-1:0]  out_data,
  output logic               out_last,
  output logic               out_tag_valid,
  output logic [TTWIDTH-1:0] out_tag_type,
  input  logic               out_ready
);

  // Room for a new beat when the slot is empty or its beat leaves this cycle; none in reset.
  assign in_ready = aresetn & (~out_valid | out_ready);

  // Load or retire the held beat; sideband fields are cleared whenever no beat is loaded.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!aresetn) begin
      // NOTE: the payload register is reset too, because downstream observes it as zero in reset.
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      out_tag_valid <= 1'b0;
      out_tag_type  <= '0;
    end else if (in_ready) begin
      out_valid     <= in_valid;
      out_last      <= in_valid & in_last;
      out_tag_valid <= in_valid & in_tag_valid;
      out_tag_type  <= (in_valid & in_tag_valid) ? in_tag_type : '0;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/rwt_tag_extract.sv
// Strips in-band escape sequences from an AXI-Stream and converts them into
// sideband tags on the following payload beat. With use_tags low it is a plain
// registered pipe.
module rwt_tag_extract
  import rwt_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int TTWIDTH = TTWIDTH_DEF
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               use_tags,
  input  logic [DWIDTH-1:0]  tag_escape,
  input  logic [DWIDTH-1:0]  s_axi_tdata,
  input  logic               s_axi_tvalid,
  output logic               s_axi_tready,
  input  logic               s_axi_tlast,
  output logic [DWIDTH-1:0]  m_axi_tdata,
  output logic               m_axi_tvalid,
  input  logic               m_axi_tready,
  output logic               m_axi_tlast,
  output logic               m_axi_tag_valid,
  output logic [TTWIDTH-1:0] m_axi_tag_type
);

  state_t             state_q, state_d;
  logic [TTWIDTH-1:0] type_q, type_d;
  logic               accept;
  logic               is_escape;
  logic               emit;
  logic               emit_tag;
  logic [TTWIDTH-1:0] emit_type;

  assign accept    = s_axi_tvalid & s_axi_tready;
  assign is_escape = (s_axi_tdata == tag_escape);

  // Decoder state and latched tag type advance only on accepted beats.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
    end
  end

  // Next-state and emit decision for the beat being accepted this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d   = state_q;
    type_d    = type_q;
    emit      = 1'b0;
    emit_tag  = 1'b0;
    emit_type = '0;
    if (accept) begin
      if (!use_tags) begin
        emit    = 1'b1;
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!is_escape)       emit    = 1'b1;
            else if (s_axi_tlast) state_d = IDLE;  // lone escape ends the packet: drop it
            else                  state_d = ESC;
          end
          ESC: begin
            if (is_escape) begin
              emit    = 1'b1;                      // doubled escape is a literal escape word
              state_d = IDLE;
            end else if (s_axi_tlast) begin
              state_d = IDLE;                      // header ends the packet: drop the sequence
            end else begin
              type_d  = s_axi_tdata[TTWIDTH-1:0];
              state_d = HDR;
            end
          end
          HDR: begin
            emit      = 1'b1;                      // payload is data even if it equals the escape
            emit_tag  = 1'b1;
            emit_type = type_q;
            state_d   = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  rwt_axis_reg #(
    .DWIDTH  (DWIDTH),
    .TTWIDTH (TTWIDTH)
  ) u_out_reg (
    .clk           (clk),
    .aresetn       (aresetn),
    .in_valid      (emit),
    .in_data       (s_axi_tdata),
    .in_last       (s_axi_tlast),
    .in_tag_valid  (emit_tag),
    .in_tag_type   (emit_type),
    .in_ready      (s_axi_tready),
    .out_valid     (m_axi_tvalid),
    .out_data      (m_axi_tdata),
    .out_last      (m_axi_tlast),
    .out_tag_valid (m_axi_tag_valid),
    .out_tag_type  (m_axi_tag_type),
    .out_ready     (m_axi_tready)
  );

endmodule

// File: tb/tb_rwt_tag_extract.sv
// Bench for rwt_tag_extract: directed cases plus randomized streams, scored
// against a sequence-buffer model of the escape rules.
module tb_rwt_tag_extract;

  localparam logic [63:0] E      = {16{4'hA}};
  localparam int          BUDGET = 5000;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic        u;
  } beat_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic        tv;
    logic [6:0]  tt;
  } out_t;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        use_tags = 1'b1;
  logic [63:0] tag_escape = E;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        m_tag_valid;
  logic [6:0]  m_tag_type;

  int checks = 0;
  int errors = 0;

  beat_t       in_q[$];
  out_t        exp_q[$];
  logic [63:0] seq[$];   // escape-sequence words collected so far

  always #5 clk = ~clk;

  rwt_tag_extract dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .use_tags        (use_tags),
    .tag_escape      (tag_escape),
    .s_axi_tdata     (s_tdata),
    .s_axi_tvalid    (s_tvalid),
    .s_axi_tready    (s_tready),
    .s_axi_tlast     (s_tlast),
    .m_axi_tdata     (m_tdata),
    .m_axi_tvalid    (m_tvalid),
    .m_axi_tready    (m_tready),
    .m_axi_tlast     (m_tlast),
    .m_axi_tag_valid (m_tag_valid),
    .m_axi_tag_type  (m_tag_type)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic l, input logic u);
    beat_t b;
    b.d = d; b.l = l; b.u = u;
    in_q.push_back(b);
  endtask

  task automatic expect_out(input logic [63:0] d, input logic l, input logic tv,
                            input logic [6:0] tt);
    out_t o;
    o.d = d; o.l = l; o.tv = tv; o.tt = tt;
    exp_q.push_back(o);
  endtask

  // Reference: buffer escape-sequence words; a sequence of length 3 yields a tagged payload.
  task automatic model_beat(input beat_t b);
    logic [63:0] hdr;
    if (!b.u) begin
      seq.delete();
      expect_out(b.d, b.l, 1'b0, 7'd0);
    end else if (seq.size() == 0) begin
      if (b.d != E)  expect_out(b.d, b.l, 1'b0, 7'd0);
      else if (!b.l) seq.push_back(b.d);
    end else if (seq.size() == 1) begin
      if (b.d == E) begin
        expect_out(E, b.l, 1'b0, 7'd0);
        seq.delete();
      end else if (b.l) begin
        seq.delete();
      end else begin
        seq.push_back(b.d);
      end
    end else begin
      hdr = seq[1];
      expect_out(b.d, b.l, 1'b1, hdr[6:0]);
      seq.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_s_tready",  s_tready,    0);
    check("rst_m_tvalid",  m_tvalid,    0);
    check("rst_m_tdata",   m_tdata,     0);
    check("rst_m_tlast",   m_tlast,     0);
    check("rst_tag_valid", m_tag_valid, 0);
    check("rst_tag_type",  m_tag_type,  0);
    aresetn = 1'b1;
    seq.delete();
    exp_q.delete();
  endtask

  // vmode 0: valid always when data pending, 1: random gaps.
  // rmode 0: ready high, 1: toggle each clk, 2: random.
  task automatic run_stream(input int vmode, input int rmode, output int cycles);
    beat_t b;
    out_t  o;
    out_t  held;
    bit    held_v = 1'b0;
    int    k = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && k < BUDGET) begin
      @(negedge clk);
      if (in_q.size() != 0 && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
        s_tvalid = 1'b1;
        s_tdata  = in_q[0].d;
        s_tlast  = in_q[0].l;
        use_tags = in_q[0].u;
      end else begin
        s_tvalid = 1'b0;
      end
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = (k % 2 == 0);
        default: m_tready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      if (held_v) begin
        check("hold_valid", m_tvalid,    1);
        check("hold_data",  m_tdata,     held.d);
        check("hold_last",  m_tlast,     held.l);
        check("hold_tagv",  m_tag_valid, held.tv);
        check("hold_tagt",  m_tag_type,  held.tt);
      end
      held_v = 1'b0;
      if (s_tvalid && s_tready) begin
        b = in_q.pop_front();
        model_beat(b);
      end
      if (m_tvalid) begin
        if (m_tready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", m_tdata, 64'hDEAD_0000_0000_DEAD ^ m_tdata ^ 64'h1);
          end else begin
            o = exp_q.pop_front();
            check("out_data", m_tdata,     o.d);
            check("out_last", m_tlast,     o.l);
            check("out_tagv", m_tag_valid, o.tv);
            check("out_tagt", m_tag_type,  o.tt);
          end
        end else begin
          held.d = m_tdata; held.l = m_tlast; held.tv = m_tag_valid; held.tt = m_tag_type;
          held_v = 1'b1;
        end
      end
      k++;
    end
    cycles = k;
    check("stream_drained", 64'(in_q.size() + exp_q.size()), 0);
    @(negedge clk);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    #1;
    check("idle_after", m_tvalid, 0);
  endtask

  initial begin
    int cyc;
    logic [63:0] d;
    int r;

    do_reset();

    // Case 1: plain beats, full throughput, one clock latency.
    push(64'd1, 0, 1); push(64'd2, 0, 1); push(64'd3, 1, 1);
    run_stream(0, 0, cyc);
    check("case1_cycles", 64'(cyc), 4);

    // Case 2: doubled escape is a literal.
    push(64'd5, 0, 1); push(E, 0, 1); push(E, 0, 1); push(64'd6, 1, 1);
    run_stream(0, 0, cyc);

    // Case 3: tagged payload.
    push(64'd7, 0, 1); push(E, 0, 1); push(64'd3, 0, 1); push(64'h1234, 1, 1);
    run_stream(0, 0, cyc);

    // Case 4: back-to-back tags, escape word as payload.
    push(E, 0, 1); push(64'h7F, 0, 1); push(64'hBEEF, 0, 1);
    push(E, 0, 1); push(64'h01, 0, 1); push(E, 0, 1);
    run_stream(0, 0, cyc);

    // Case 5: case 3 under toggling back-pressure.
    push(64'd7, 0, 1); push(E, 0, 1); push(64'd3, 0, 1); push(64'h1234, 1, 1);
    run_stream(0, 1, cyc);

    // Truncated sequences: escape with last, header with last.
    push(E, 1, 1); push(64'd8, 0, 1); push(E, 0, 1); push(64'd9, 1, 1); push(64'd10, 1, 1);
    run_stream(0, 0, cyc);

    // Case 6: pass-through, then reset in the middle of a sequence.
    push(E, 0, 0); push(64'h03, 0, 0); push(64'h9, 1, 0);
    run_stream(0, 0, cyc);
    push(E, 0, 1);
    run_stream(0, 0, cyc);
    do_reset();
    push(64'h4, 0, 1);
    run_stream(0, 0, cyc);

    // Randomized streams with gaps, back-pressure and occasional use_tags drops.
    for (int s = 0; s < 6; s++) begin
      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 9);
        if (r < 4)      d = E;
        else if (r < 7) d = 64'($urandom_range(0, 127));
        else            d = {$urandom, $urandom};
        push(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) != 0));
      end
      run_stream(1, s % 3, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
